// File: rtl/hwpe_ctrl_tile_sequencer_pkg.sv
// Shared types and register map for the HWPE tile sequencer.
// The optional performance counters are enabled with HWPE_CTRL_TILE_SEQ_PERF_EN.
package hwpe_ctrl_tile_sequencer_pkg;

    // Sequencer FSM states
    typedef enum logic [2:0] {
        TS_IDLE,
        TS_ISSUE,
        TS_WAIT,
        TS_NEXT,
        TS_DONE
    } tile_seq_state_t;

    // Default field widths of the tiling configuration as seen by software
    localparam int unsigned TS_ADDR_W = 32;
    localparam int unsigned TS_CNT_W  = 16;

    // Tiling configuration as held in the control register file
    typedef struct packed {
        logic [TS_CNT_W-1:0]  n_inner;
        logic [TS_CNT_W-1:0]  n_outer;
        logic [TS_ADDR_W-1:0] base;
        logic [TS_ADDR_W-1:0] stride_inner;
        logic [TS_ADDR_W-1:0] stride_outer;
    } tile_seq_cfg_t;

    // Word offsets of the tiling fields inside the generic register area
    localparam int unsigned TS_REG_N_INNER      = 0;
    localparam int unsigned TS_REG_N_OUTER      = 1;
    localparam int unsigned TS_REG_BASE         = 2;
    localparam int unsigned TS_REG_STRIDE_INNER = 3;
    localparam int unsigned TS_REG_STRIDE_OUTER = 4;

endpackage

// File: rtl/hwpe_ctrl_tile_sequencer_if.sv
// Per-tile handshake between the tile sequencer (master) and the engine (slave).
interface hwpe_ctrl_tile_sequencer_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
);
    logic                  tile_start;
    logic [ADDR_WIDTH-1:0] tile_addr;
    logic [CNT_WIDTH-1:0]  tile_idx_inner;
    logic [CNT_WIDTH-1:0]  tile_idx_outer;
    logic                  tile_done;

    modport master (
        output tile_start,
        output tile_addr,
        output tile_idx_inner,
        output tile_idx_outer,
        input  tile_done
    );

    modport slave (
        input  tile_start,
        input  tile_addr,
        input  tile_idx_inner,
        input  tile_idx_outer,
        output tile_done
    );
endinterface

// File: rtl/hwpe_ctrl_tile_sequencer_addrgen.sv
// Tile index counters and inner/outer address registers of the tile sequencer.
// init_i loads the job origin, advance_i steps to the next tile in row-major order.
module hwpe_ctrl_tile_sequencer_addrgen #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  init_i,
    input  logic                  advance_i,
    input  logic [ADDR_WIDTH-1:0] base_i,
    input  logic [ADDR_WIDTH-1:0] stride_inner_i,
    input  logic [ADDR_WIDTH-1:0] stride_outer_i,
    input  logic [CNT_WIDTH-1:0]  n_inner_i,
    input  logic [CNT_WIDTH-1:0]  n_outer_i,
    output logic [CNT_WIDTH-1:0]  idx_inner_o,
    output logic [CNT_WIDTH-1:0]  idx_outer_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  last_inner_o,
    output logic                  last_outer_o
);

    logic [CNT_WIDTH-1:0]  idx_inner_q;
    logic [CNT_WIDTH-1:0]  idx_outer_q;
    logic [ADDR_WIDTH-1:0] inner_addr_q;
    logic [ADDR_WIDTH-1:0] outer_addr_q;

    // Compare index+1 against the count one bit wider so the maximum count never wraps
    always_comb begin
        last_inner_o = (({1'b0, idx_inner_q} + {{CNT_WIDTH{1'b0}}, 1'b1}) == {1'b0, n_inner_i});
        last_outer_o = (({1'b0, idx_outer_q} + {{CNT_WIDTH{1'b0}}, 1'b1}) == {1'b0, n_outer_i});
    end

    assign idx_inner_o = idx_inner_q;
    assign idx_outer_o = idx_outer_q;
    assign addr_o      = inner_addr_q;

    // Index and address registers; an outer step restarts the row from the new row origin
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_inner_q  <= '0;
            idx_outer_q  <= '0;
            inner_addr_q <= '0;
            outer_addr_q <= '0;
        end else if (clear_i) begin
            idx_inner_q  <= '0;
            idx_outer_q  <= '0;
            inner_addr_q <= '0;
            outer_addr_q <= '0;
        end else if (init_i) begin
            idx_inner_q  <= '0;
            idx_outer_q  <= '0;
            inner_addr_q <= base_i;
            outer_addr_q <= base_i;
        end else if (advance_i) begin
            if (!last_inner_o) begin
                idx_inner_q  <= idx_inner_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                inner_addr_q <= inner_addr_q + stride_inner_i;
            end else if (!last_outer_o) begin
                idx_inner_q  <= '0;
                idx_outer_q  <= idx_outer_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                outer_addr_q <= outer_addr_q + stride_outer_i;
                inner_addr_q <= outer_addr_q + stride_outer_i;
            end
        end
    end

endmodule

// File: rtl/hwpe_ctrl_tile_sequencer.sv
// Sequences one HWPE job as a 2-D nest of tiles: one engine start per tile,
// one job-done pulse after the last tile.
// Optional busy/wait cycle counters are enabled with HWPE_CTRL_TILE_SEQ_PERF_EN.
module hwpe_ctrl_tile_sequencer
    import hwpe_ctrl_tile_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clear_i,
    input  logic                       start_i,
    input  logic [CNT_WIDTH-1:0]       n_inner_i,
    input  logic [CNT_WIDTH-1:0]       n_outer_i,
    input  logic [ADDR_WIDTH-1:0]      base_addr_i,
    input  logic [ADDR_WIDTH-1:0]      stride_inner_i,
    input  logic [ADDR_WIDTH-1:0]      stride_outer_i,
    hwpe_ctrl_tile_sequencer_if.master eng,
    output logic                       done_o,
    output logic                       busy_o
`ifdef HWPE_CTRL_TILE_SEQ_PERF_EN
    ,
    output logic [31:0]                perf_busy_cycles_o,
    output logic [31:0]                perf_wait_cycles_o
`endif
);

    tile_seq_state_t state_q, state_d;

    logic [CNT_WIDTH-1:0]  n_inner_q;
    logic [CNT_WIDTH-1:0]  n_outer_q;
    logic [ADDR_WIDTH-1:0] stride_inner_q;
    logic [ADDR_WIDTH-1:0] stride_outer_q;

    logic                  init;
    logic                  advance;
    logic                  accept;
    logic                  last_inner;
    logic                  last_outer;
    logic [ADDR_WIDTH-1:0] addr;
    logic [CNT_WIDTH-1:0]  idx_inner;
    logic [CNT_WIDTH-1:0]  idx_outer;

    assign accept = (state_q == TS_IDLE) && start_i;

    // Next-state and strobe decode
    always_comb begin
        state_d = state_q;
        init    = 1'b0;
        advance = 1'b0;
        case (state_q)
            TS_IDLE: begin
                if (start_i) begin
                    init    = 1'b1;
                    state_d = ((n_inner_i == '0) || (n_outer_i == '0)) ? TS_DONE : TS_ISSUE;
                end
            end
            TS_ISSUE: state_d = TS_WAIT;
            TS_WAIT: begin
                if (eng.tile_done) begin
                    state_d = TS_NEXT;
                end
            end
            TS_NEXT: begin
                advance = 1'b1;
                state_d = (last_inner && last_outer) ? TS_DONE : TS_ISSUE;
            end
            TS_DONE: state_d = TS_IDLE;
            default: state_d = TS_IDLE;
        endcase
    end

    // State register; clear aborts the job from any state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= TS_IDLE;
        end else if (clear_i) begin
            state_q <= TS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Job configuration captured at start so input changes mid-job have no effect
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            n_inner_q      <= '0;
            n_outer_q      <= '0;
            stride_inner_q <= '0;
            stride_outer_q <= '0;
        end else if (clear_i) begin
            n_inner_q      <= '0;
            n_outer_q      <= '0;
            stride_inner_q <= '0;
            stride_outer_q <= '0;
        end else if (init) begin
            n_inner_q      <= n_inner_i;
            n_outer_q      <= n_outer_i;
            stride_inner_q <= stride_inner_i;
            stride_outer_q <= stride_outer_i;
        end
    end

    hwpe_ctrl_tile_sequencer_addrgen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) i_addrgen (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .clear_i        (clear_i),
        .init_i         (init),
        .advance_i      (advance),
        .base_i         (base_addr_i),
        .stride_inner_i (stride_inner_q),
        .stride_outer_i (stride_outer_q),
        .n_inner_i      (n_inner_q),
        .n_outer_i      (n_outer_q),
        .idx_inner_o    (idx_inner),
        .idx_outer_o    (idx_outer),
        .addr_o         (addr),
        .last_inner_o   (last_inner),
        .last_outer_o   (last_outer)
    );

    // Pulses are suppressed while clear is asserted so an aborted job never signals
    assign eng.tile_start     = (state_q == TS_ISSUE) && !clear_i;
    assign eng.tile_addr      = addr;
    assign eng.tile_idx_inner = idx_inner;
    assign eng.tile_idx_outer = idx_outer;
    assign done_o             = (state_q == TS_DONE) && !clear_i;
    assign busy_o             = (state_q != TS_IDLE);

`ifdef HWPE_CTRL_TILE_SEQ_PERF_EN
    logic [31:0] perf_busy_q;
    logic [31:0] perf_wait_q;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Saturating cycle counters, restarted by each accepted job and held afterwards
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_busy_q <= '0;
            perf_wait_q <= '0;
        end else if (clear_i || accept) begin
            perf_busy_q <= '0;
            perf_wait_q <= '0;
        end else begin
            if (busy_o) begin
                perf_busy_q <= sat_inc(perf_busy_q);
            end
            if (state_q == TS_WAIT) begin
                perf_wait_q <= sat_inc(perf_wait_q);
            end
        end
    end

    assign perf_busy_cycles_o = perf_busy_q;
    assign perf_wait_cycles_o = perf_wait_q;
`endif

endmodule
